// File: rtl/dmem_arb_defs.sv
// dmem_arb_defs: shared definitions for the data-RAM arbiter.
// Contents: FSM state encoding, RAM port owner encoding, latency-counter width helper.
package dmem_arb_defs;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        DMA_RD = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } arb_owner_e;

    // Width of a counter that must hold the value lat.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/dmem_lat_timer.sv
// dmem_lat_timer: loadable down-counter timing an in-flight RAM read.
// Ports:
//   i_clk    rising-edge clock
//   i_reset  synchronous active-low reset (clears the count)
//   i_load   read issued this cycle; count starts at RAM_LAT
//   o_done   final wait cycle: the count steps to zero at the coming edge
module dmem_lat_timer
    import dmem_arb_defs::*;
#(
    parameter int unsigned RAM_LAT = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    output logic o_done
);

    localparam int unsigned CW = cnt_width(RAM_LAT);

    logic [CW-1:0] r_cnt;

    // Decrements only while non-zero, so the count parks at zero in IDLE and never wraps.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(RAM_LAT);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == CW'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU MEM stage and a DMA requester.
// Ports:
//   i_clk, i_reset                clock, synchronous active-low reset (forces all outputs to 0)
//   i_cpu_req/we/addr/wdata       CPU access, held while o_cpu_stall=1
//   o_cpu_rdata, o_cpu_stall      registered CPU read data, pipeline hold
//   i_dma_req/we/addr/wdata       DMA access, held until o_dma_gnt
//   o_dma_gnt, o_dma_rdata, o_dma_rvalid  issue pulse, registered read data, data-valid pulse
//   o_ram_en/we/addr/wdata, i_ram_rdata   single-port RAM interface
// Build option: DMEM_ARB_STARVE_EN forces a DMA grant after STARVE_MAX CPU issues made while
//   DMA was waiting; without it the CPU has strict priority.
module dmem_arbiter
    import dmem_arb_defs::*;
#(
    parameter int unsigned DW         = 32,
    parameter int unsigned ADDR_BITS  = 10,
`ifdef DMEM_ARB_STARVE_EN
    parameter int unsigned STARVE_MAX = 8,
`endif
    parameter int unsigned RAM_LAT    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_cpu_req,
    input  logic                 i_cpu_we,
    input  logic [31:0]          i_cpu_addr,
    input  logic [DW-1:0]        i_cpu_wdata,
    output logic [DW-1:0]        o_cpu_rdata,
    output logic                 o_cpu_stall,
    input  logic                 i_dma_req,
    input  logic                 i_dma_we,
    input  logic [31:0]          i_dma_addr,
    input  logic [DW-1:0]        i_dma_wdata,
    output logic                 o_dma_gnt,
    output logic [DW-1:0]        o_dma_rdata,
    output logic                 o_dma_rvalid,
    output logic                 o_ram_en,
    output logic                 o_ram_we,
    output logic [ADDR_BITS-1:0] o_ram_addr,
    output logic [DW-1:0]        o_ram_wdata,
    input  logic [DW-1:0]        i_ram_rdata
);

    arb_state_e           r_state, w_state_nxt;
    arb_owner_e           w_owner;
    logic                 r_cpu_done;
    logic [DW-1:0]        r_cpu_rdata, r_dma_rdata;
    logic                 r_dma_rvalid;
    logic                 w_cpu_want, w_force_dma, w_issue, w_rd_issue, w_timer_done;
    logic                 w_cpu_stall, w_dma_gnt, w_ram_we;
    logic [ADDR_BITS-1:0] w_ram_addr;
    logic [DW-1:0]        w_ram_wdata;
    logic                 w_unused_addr;

    // Byte-lane bits and bits above the RAM window are deliberately ignored (aliasing).
    assign w_unused_addr = ^{i_cpu_addr[31:ADDR_BITS+2], i_cpu_addr[1:0],
                             i_dma_addr[31:ADDR_BITS+2], i_dma_addr[1:0]};

    // A CPU read's request is still high in its completion cycle; it must not reissue.
    assign w_cpu_want = i_cpu_req && !r_cpu_done;

`ifdef DMEM_ARB_STARVE_EN
    localparam int unsigned SW = cnt_width(STARVE_MAX);
    logic [SW-1:0] r_starve_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_starve_cnt <= '0;
        end else if (w_dma_gnt) begin
            r_starve_cnt <= '0;
        end else if (w_issue && (w_owner == OWN_CPU) && i_dma_req &&
                     (r_starve_cnt != SW'(STARVE_MAX))) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign w_force_dma = i_dma_req && (r_starve_cnt == SW'(STARVE_MAX));
`else
    assign w_force_dma = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_owner     = OWN_CPU;
        w_cpu_stall = 1'b0;
        w_dma_gnt   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_cpu_want && !w_force_dma) begin
                    w_issue     = 1'b1;
                    w_cpu_stall = !i_cpu_we;
                    if (!i_cpu_we) w_state_nxt = CPU_RD;
                end else if (i_dma_req) begin
                    w_issue     = 1'b1;
                    w_owner     = OWN_DMA;
                    w_dma_gnt   = 1'b1;
                    w_cpu_stall = w_cpu_want;
                    if (!i_dma_we) w_state_nxt = DMA_RD;
                end
            end
            CPU_RD, DMA_RD: begin
                w_cpu_stall = i_cpu_req;
                if (w_timer_done) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_addr  = '0;
        w_ram_wdata = '0;
        if (w_issue) begin
            if (w_owner == OWN_DMA) begin
                w_ram_we    = i_dma_we;
                w_ram_addr  = i_dma_addr[ADDR_BITS+1:2];
                w_ram_wdata = i_dma_wdata;
            end else begin
                w_ram_we    = i_cpu_we;
                w_ram_addr  = i_cpu_addr[ADDR_BITS+1:2];
                w_ram_wdata = i_cpu_wdata;
            end
        end
    end

    assign w_rd_issue = w_issue && !w_ram_we;

    dmem_lat_timer #(
        .RAM_LAT (RAM_LAT)
    ) u_lat_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_rd_issue),
        .o_done  (w_timer_done)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state      <= IDLE;
            r_cpu_done   <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
            r_dma_rvalid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cpu_done   <= (r_state == CPU_RD) && w_timer_done;
            r_dma_rvalid <= (r_state == DMA_RD) && w_timer_done;
            if ((r_state == CPU_RD) && w_timer_done) r_cpu_rdata <= i_ram_rdata;
            if ((r_state == DMA_RD) && w_timer_done) r_dma_rdata <= i_ram_rdata;
        end
    end

    assign o_ram_en     = i_reset && w_issue;
    assign o_ram_we     = i_reset && w_ram_we;
    assign o_ram_addr   = i_reset ? w_ram_addr : '0;
    assign o_ram_wdata  = i_reset ? w_ram_wdata : '0;
    assign o_cpu_stall  = i_reset && w_cpu_stall;
    assign o_dma_gnt    = i_reset && w_dma_gnt;
    assign o_cpu_rdata  = i_reset ? r_cpu_rdata : '0;
    assign o_dma_rdata  = i_reset ? r_dma_rdata : '0;
    assign o_dma_rvalid = i_reset && r_dma_rvalid;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter (RAM_LAT=1 instance plus a RAM_LAT=3
// instance), with behavioural RAM models, a vector table, directed sequences and a random run
// checked against a golden memory.
module tb_dmem_arbiter;

    localparam int unsigned AB = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cpu_req, cpu_we, cpu_stall;
    logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
    logic          dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [31:0]   dma_addr, dma_wdata, dma_rdata;
    logic          ram_en, ram_we;
    logic [AB-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;
    logic [31:0]   mem1 [0:1023];

    logic          c3_req, c3_we, c3_stall, d3_gnt, d3_rvalid, r3_en, r3_we;
    logic [31:0]   c3_addr, c3_wdata, c3_rdata, d3_rdata, r3_wdata, r3_rdata;
    logic [AB-1:0] r3_addr;
    logic [31:0]   mem3 [0:1023];
    logic [31:0]   pipe3 [0:2];

    dmem_arbiter #(.DW(32), .ADDR_BITS(AB), .RAM_LAT(1)) u_dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
        .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
        .o_dma_gnt(dma_gnt), .o_dma_rdata(dma_rdata), .o_dma_rvalid(dma_rvalid),
        .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
        .i_ram_rdata(ram_rdata)
    );

    dmem_arbiter #(.DW(32), .ADDR_BITS(AB), .RAM_LAT(3)) u_dut3 (
        .i_clk(clk), .i_reset(rst_n),
        .i_cpu_req(c3_req), .i_cpu_we(c3_we), .i_cpu_addr(c3_addr), .i_cpu_wdata(c3_wdata),
        .o_cpu_rdata(c3_rdata), .o_cpu_stall(c3_stall),
        .i_dma_req(1'b0), .i_dma_we(1'b0), .i_dma_addr(32'h0), .i_dma_wdata(32'h0),
        .o_dma_gnt(d3_gnt), .o_dma_rdata(d3_rdata), .o_dma_rvalid(d3_rvalid),
        .o_ram_en(r3_en), .o_ram_we(r3_we), .o_ram_addr(r3_addr), .o_ram_wdata(r3_wdata),
        .i_ram_rdata(r3_rdata)
    );

    // RAM models: write in the issue cycle, read data RAM_LAT cycles after issue.
    always @(posedge clk) begin
        if (ram_en && ram_we) mem1[ram_addr] <= ram_wdata;
        if (ram_en && !ram_we) ram_rdata <= mem1[ram_addr];
    end

    always @(posedge clk) begin
        if (r3_en && r3_we) mem3[r3_addr] <= r3_wdata;
        if (r3_en && !r3_we) pipe3[0] <= mem3[r3_addr];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign r3_rdata = pipe3[2];

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        total++;
        bad++;
        $display("FAIL %s: got %s", name, what);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    endtask

    function automatic logic [9:0] word_of(input logic [31:0] a);
        return a[11:2];
    endfunction

    // Pool of words 32..47 with random alias bits above the window and in the byte lane.
    function automatic logic [31:0] rnd_addr();
        logic [31:0] r;
        r = $urandom;
        return (r & ~32'h0000_0FFC) | (32'($urandom_range(32, 47)) << 2);
    endfunction

    typedef struct {
        logic [1:0]  c;    // {cpu_req, cpu_we}
        logic [31:0] ca, cd;
        logic [1:0]  d;    // {dma_req, dma_we}
        logic [31:0] da, dd;
        logic [1:0]  enwe; // expected {ram_en, ram_we}
        logic [9:0]  a;
        logic [31:0] wd;
        logic [1:0]  stg;  // expected {cpu_stall, dma_gnt}
        logic [31:0] rd;   // expected cpu_rdata
    } vec_t;

    function automatic vec_t mk(input logic [1:0] c, input logic [31:0] ca, cd,
                                input logic [1:0] d, input logic [31:0] da, dd,
                                input logic [1:0] enwe, input logic [9:0] a,
                                input logic [31:0] wd, input logic [1:0] stg,
                                input logic [31:0] rd);
        vec_t v;
        v.c = c; v.ca = ca; v.cd = cd; v.d = d; v.da = da; v.dd = dd;
        v.enwe = enwe; v.a = a; v.wd = wd; v.stg = stg; v.rd = rd;
        return v;
    endfunction

    localparam int NV = 12;
    vec_t vecs [NV];

    logic [31:0] gmem [0:1023];
    logic [31:0] exp_q [$];
    logic [9:0]  w;
    int          first_gnt, exp_first, stall_cnt, exp_stall_cnt, n;
    int          cwait, dwait;
    logic        cpu_pend, dma_pend;

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem1[i] = 0; mem3[i] = 0; gmem[i] = 0;
        end
        for (int i = 0; i < 3; i++) pipe3[i] = 0;
        ram_rdata = 0;
        c3_req = 0; c3_we = 0; c3_addr = 0; c3_wdata = 0;
        idle_inputs();

        // Reset: outputs forced low even with active requests.
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'h1;
        dma_req = 1; dma_we = 0;
        tick(); tick(); #4;
        chk("reset ram_en", 32'(ram_en), 0);
        chk("reset cpu_stall", 32'(cpu_stall), 0);
        chk("reset dma_gnt", 32'(dma_gnt), 0);
        chk("reset cpu_rdata", cpu_rdata, 0);
        chk("reset dma_rvalid", 32'(dma_rvalid), 0);
        tick(); rst_n = 1; idle_inputs();

        vecs[0]  = mk(2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0);
        vecs[1]  = mk(2'b11, 'h10, 'hDEADBEEF, 2'b00, 0, 0, 2'b11, 4, 'hDEADBEEF, 2'b00, 0);
        vecs[2]  = mk(2'b11, 'h1017, 'h0BADF00D, 2'b00, 0, 0, 2'b11, 5, 'h0BADF00D, 2'b00, 0);
        vecs[3]  = mk(2'b11, 'h18, 'h66666666, 2'b11, 'h20, 'hAAAAAAAA,
                      2'b11, 6, 'h66666666, 2'b00, 0);
        vecs[4]  = mk(2'b00, 0, 0, 2'b11, 'h20, 'hAAAAAAAA, 2'b11, 8, 'hAAAAAAAA, 2'b01, 0);
        vecs[5]  = mk(2'b10, 'h14, 0, 2'b00, 0, 0, 2'b10, 5, 0, 2'b10, 0);
        vecs[6]  = mk(2'b10, 'h14, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b10, 0);
        vecs[7]  = mk(2'b10, 'h14, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 'h0BADF00D);
        vecs[8]  = mk(2'b10, 'h10, 0, 2'b11, 'h20, 'h12345678, 2'b10, 4, 0, 2'b10, 'h0BADF00D);
        vecs[9]  = mk(2'b10, 'h10, 0, 2'b11, 'h20, 'h12345678, 2'b00, 0, 0, 2'b10, 'h0BADF00D);
        vecs[10] = mk(2'b10, 'h10, 0, 2'b11, 'h20, 'h12345678,
                      2'b11, 8, 'h12345678, 2'b01, 'hDEADBEEF);
        vecs[11] = mk(2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 'hDEADBEEF);

        for (int i = 0; i < NV; i++) begin
            tick();
            {cpu_req, cpu_we} = vecs[i].c; cpu_addr = vecs[i].ca; cpu_wdata = vecs[i].cd;
            {dma_req, dma_we} = vecs[i].d; dma_addr = vecs[i].da; dma_wdata = vecs[i].dd;
            #4;
            chk($sformatf("vec%0d ram_en", i), 32'(ram_en), 32'(vecs[i].enwe[1]));
            chk($sformatf("vec%0d ram_we", i), 32'(ram_we), 32'(vecs[i].enwe[0]));
            chk($sformatf("vec%0d cpu_stall", i), 32'(cpu_stall), 32'(vecs[i].stg[1]));
            chk($sformatf("vec%0d dma_gnt", i), 32'(dma_gnt), 32'(vecs[i].stg[0]));
            chk($sformatf("vec%0d cpu_rdata", i), cpu_rdata, vecs[i].rd);
            if (vecs[i].enwe[1])
                chk($sformatf("vec%0d ram_addr", i), 32'(ram_addr), 32'(vecs[i].a));
            if (vecs[i].enwe[0])
                chk($sformatf("vec%0d ram_wdata", i), ram_wdata, vecs[i].wd);
        end
        tick(); idle_inputs(); #4;
        chk("collision ram word8", mem1[8], 32'h12345678);
        chk("alias ram word5", mem1[5], 32'h0BADF00D);

        // DMA read in flight while the CPU raises a read.
        tick(); dma_req = 1; dma_we = 0; dma_addr = 32'h10; #4;
        chk("dmard issue gnt", 32'(dma_gnt), 1);
        tick(); dma_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h18; #4;
        chk("dmard T+1 stall", 32'(cpu_stall), 1);
        chk("dmard T+1 rvalid", 32'(dma_rvalid), 0);
        tick(); #4;
        chk("dmard T+2 rvalid", 32'(dma_rvalid), 1);
        chk("dmard T+2 rdata", dma_rdata, 32'hDEADBEEF);
        chk("dmard T+2 cpu issue", 32'({ram_en, ram_we}), 32'(2'b10));
        chk("dmard T+2 cpu addr", 32'(ram_addr), 6);
        chk("dmard T+2 stall", 32'(cpu_stall), 1);
        tick(); #4;
        chk("dmard T+3 rvalid", 32'(dma_rvalid), 0);
        tick(); #4;
        chk("dmard cpu done stall", 32'(cpu_stall), 0);
        chk("dmard cpu rdata", cpu_rdata, 32'h66666666);

        // Reset in the cycle after a CPU read issue.
        tick(); cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; #4;
        chk("rstrd issue stall", 32'(cpu_stall), 1);
        tick(); rst_n = 0; #4;
        chk("rstrd during stall", 32'(cpu_stall), 0);
        tick(); rst_n = 1; idle_inputs(); #4;
        chk("rstrd after stall", 32'(cpu_stall), 0);
        chk("rstrd after rdata", cpu_rdata, 0);
        chk("rstrd after rvalid", 32'(dma_rvalid), 0);
        tick(); #4;
        chk("rstrd later rdata", cpu_rdata, 0);
        chk("rstrd later ram_en", 32'(ram_en), 0);

        // Continuous CPU writes with DMA waiting.
        tick(); rst_n = 0; tick(); rst_n = 1;
        first_gnt = -1; stall_cnt = 0; dma_pend = 1;
        for (int k = 0; k < 12; k++) begin
            tick();
            cpu_req = 1; cpu_we = 1; cpu_addr = 32'h100; cpu_wdata = k;
            dma_req = dma_pend; dma_we = 1; dma_addr = 32'h140; dma_wdata = 32'h5A5A5A5A;
            #4;
            if (cpu_stall) stall_cnt++;
            if (dma_gnt) begin
                if (first_gnt < 0) first_gnt = k;
                dma_pend = 0;
            end
        end
`ifdef DMEM_ARB_STARVE_EN
        exp_first = 8; exp_stall_cnt = 1;
`else
        exp_first = -1; exp_stall_cnt = 0;
`endif
        chk("starve first gnt", 32'(first_gnt), 32'(exp_first));
        chk("starve cpu stalls", 32'(stall_cnt), 32'(exp_stall_cnt));
        tick(); idle_inputs();

        // Random traffic against a golden memory.
        cpu_pend = 0; dma_pend = 0; cwait = 0; dwait = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (!cpu_pend && cyc < 2950 && $urandom_range(0, 3) != 0) begin
                cpu_pend = 1; cwait = 0;
                cpu_we = 1'($urandom_range(0, 1)); cpu_addr = rnd_addr(); cpu_wdata = $urandom;
            end
            cpu_req = cpu_pend;
            if (!dma_pend && cyc < 2950 && $urandom_range(0, 2) == 0) begin
                dma_pend = 1; dwait = 0;
                dma_we = 1'($urandom_range(0, 1)); dma_addr = rnd_addr(); dma_wdata = $urandom;
            end
            dma_req = dma_pend;
            #4;
            if (cpu_pend) begin
                if (!cpu_stall) begin
                    w = word_of(cpu_addr);
                    if (cpu_we) gmem[w] = cpu_wdata;
                    else chk("rand cpu rdata", cpu_rdata, gmem[w]);
                    cpu_pend = 0;
                end else if (++cwait > 20) begin
                    fail("rand cpu wait", "no completion, want within 20 cycles");
                    cpu_pend = 0;
                end
            end
            if (dma_gnt) begin
                if (!dma_pend) begin
                    fail("rand dma_gnt", "grant, want none (no request)");
                end else begin
                    w = word_of(dma_addr);
                    chk("rand dma ram_addr", 32'(ram_addr), 32'(w));
                    if (dma_we) gmem[w] = dma_wdata;
                    else exp_q.push_back(gmem[w]);
                    dma_pend = 0;
                end
            end else if (dma_pend && ++dwait > 300) begin
                fail("rand dma wait", "no grant, want within 300 cycles");
                dma_pend = 0;
            end
            if (dma_rvalid) begin
                if (exp_q.size() == 0) fail("rand dma_rvalid", "rvalid, want none");
                else chk("rand dma rdata", dma_rdata, exp_q.pop_front());
            end
        end
        chk("rand dma reads drained", 32'(exp_q.size()), 0);
        idle_inputs();

        // RAM_LAT=3 instance: stall length of a read.
        tick(); c3_req = 1; c3_we = 1; c3_addr = 32'h10; c3_wdata = 32'hDEADBEEF; #4;
        chk("lat3 write stall", 32'(c3_stall), 0);
        chk("lat3 write en/we", 32'({r3_en, r3_we}), 32'(2'b11));
        tick(); c3_we = 0; #4;
        n = 0;
        while (c3_stall && n < 10) begin
            n++;
            tick(); #4;
        end
        chk("lat3 stall cycles", 32'(n), 4);
        chk("lat3 rdata", c3_rdata, 32'hDEADBEEF);
        tick(); c3_req = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
